// File: rtl/seq_pkg.sv
// Shared constants and types for the 8-byte pattern source and its downstream checker.
// Both sides import this package, so the sequence is defined in one place only.
package seq_pkg;

    localparam int SEQ_LEN = 8;

    localparam logic [7:0] SOF = 8'hAF;

    // Packed so that SEQ[0] is the frame-start byte and SEQ[7] is the last byte.
    localparam logic [SEQ_LEN-1:0][7:0] SEQ = {
        8'h8D, 8'h0B, 8'hE2, 8'hFF, 8'h78, 8'hE2, 8'hBC, 8'hAF
    };

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } seq_state_t;

    function automatic logic [7:0] seq_byte(input logic [2:0] i);
        return SEQ[i];
    endfunction

endpackage

// File: rtl/seq_checker_sat_counter.sv
// Saturating up-counter with a synchronous clear.
// A clear takes priority over an increment in the same cycle.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_checker.sv
// Stream checker for the fixed 8-byte pattern: hunts for the frame start, confirms one
// frame, then stays locked and reports per-beat mismatches and completed frames.
module seq_checker
    import seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid,
    input  logic [7:0]       data,
    input  logic             cnt_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    seq_state_t state, state_nxt;
    logic [2:0] idx, idx_nxt;
    logic       frame_hit;
    logic       err_hit;
    logic       beat_match;
    logic       beat_sof;

    assign beat_match = (data == seq_byte(idx));
    assign beat_sof   = (data == SOF);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        frame_hit = 1'b0;
        err_hit   = 1'b0;
        if (valid) begin
            case (state)
                HUNT: begin
                    if (beat_sof) begin
                        state_nxt = SYNC;
                        idx_nxt   = 3'd1;
                    end else begin
                        idx_nxt   = 3'd0;
                    end
                end
                SYNC: begin
                    if (beat_match) begin
                        idx_nxt = idx + 3'd1;
                        if (idx == 3'd7) begin
                            state_nxt = LOCKED;
                            frame_hit = 1'b1;
                        end
                    end else if (beat_sof) begin
                        idx_nxt = 3'd1;
                    end else begin
                        state_nxt = HUNT;
                        idx_nxt   = 3'd0;
                    end
                end
                LOCKED: begin
                    if (beat_match) begin
                        idx_nxt   = idx + 3'd1;
                        frame_hit = (idx == 3'd7);
                    end else begin
                        // A mismatching 0xAF may itself be the start of a fresh frame.
                        err_hit   = 1'b1;
                        state_nxt = beat_sof ? SYNC : HUNT;
                        idx_nxt   = beat_sof ? 3'd1 : 3'd0;
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    idx_nxt   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= HUNT;
            idx        <= 3'd0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            locked     <= (state_nxt == LOCKED);
            err_pulse  <= err_hit;
            frame_done <= frame_hit;
        end
    end

    sat_counter #(.W(CNT_W)) u_frame_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .inc     (frame_hit),
        .cnt     (frame_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .inc     (err_hit),
        .cnt     (err_cnt)
    );

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker: a 16-bit-counter instance for the main behaviour and a
// 2-bit-counter instance sharing the same stream for saturation and clear-priority checks.
module tb_seq_checker;

    logic        clk;
    logic        reset_n;
    logic        valid;
    logic [7:0]  data;
    logic        cnt_clr;
    logic        cnt_clr2;
    logic        locked, err_pulse, frame_done;
    logic [15:0] frame_cnt, err_cnt;
    logic        locked2, err_pulse2, frame_done2;
    logic [1:0]  frame_cnt2, err_cnt2;

    int assertions = 0;
    int failures   = 0;
    int errPulses  = 0;
    int errBefore;

    localparam logic [7:0] FRAME [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};

    seq_checker #(.CNT_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .valid      (valid),
        .data       (data),
        .cnt_clr    (cnt_clr),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
    );

    seq_checker #(.CNT_W(2)) dut2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .valid      (valid),
        .data       (data),
        .cnt_clr    (cnt_clr2),
        .locked     (locked2),
        .err_pulse  (err_pulse2),
        .frame_done (frame_done2),
        .frame_cnt  (frame_cnt2),
        .err_cnt    (err_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_pulse) errPulses++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertions++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One valid beat after 'gap' idle cycles; returns #1 after the sampling edge.
    task automatic applyStimulus(input logic [7:0] d, input int gap);
        valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        valid = 1'b1;
        data  = d;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic sendFrame(input int gapMode);
        for (int i = 0; i < 8; i++) applyStimulus(FRAME[i], (gapMode != 0) ? (i % 4) : 0);
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        reset_n = 1'b0;
        idleCycle();
        idleCycle();
        reset_n = 1'b1;
        idleCycle();
    endtask

    initial begin
        reset_n  = 1'b0;
        valid    = 1'b0;
        data     = 8'h00;
        cnt_clr  = 1'b0;
        cnt_clr2 = 1'b0;
        #1;
        checkOutput("reset_locked", 32'(locked), 32'd0);
        checkOutput("reset_frame_cnt", 32'(frame_cnt), 32'd0);
        checkOutput("reset_err_cnt", 32'(err_cnt), 32'd0);
        idleCycle();
        idleCycle();
        reset_n = 1'b1;
        idleCycle();

        // Clean frame back to back
        for (int i = 0; i < 7; i++) applyStimulus(FRAME[i], 0);
        checkOutput("t1_not_locked_yet", 32'(locked), 32'd0);
        applyStimulus(FRAME[7], 0);
        checkOutput("t1_frame_done", 32'(frame_done), 32'd1);
        checkOutput("t1_locked", 32'(locked), 32'd1);
        checkOutput("t1_frame_cnt", 32'(frame_cnt), 32'd1);
        checkOutput("t1_err_cnt", 32'(err_cnt), 32'd0);
        idleCycle();
        checkOutput("t1_frame_done_one_cycle", 32'(frame_done), 32'd0);
        checkOutput("t1_locked_holds", 32'(locked), 32'd1);

        // Mismatch at index 3 while locked, then relock
        applyStimulus(8'hAF, 0);
        applyStimulus(8'hBC, 0);
        applyStimulus(8'hE2, 0);
        applyStimulus(8'h00, 0);
        checkOutput("t2_err_pulse", 32'(err_pulse), 32'd1);
        checkOutput("t2_err_cnt", 32'(err_cnt), 32'd1);
        checkOutput("t2_locked_drops", 32'(locked), 32'd0);
        idleCycle();
        checkOutput("t2_err_pulse_one_cycle", 32'(err_pulse), 32'd0);
        sendFrame(0);
        checkOutput("t2_relocked", 32'(locked), 32'd1);
        checkOutput("t2_frame_cnt", 32'(frame_cnt), 32'd2);

        // Junk plus partial frame in HUNT/SYNC, then a frame with idle gaps
        pulseReset();
        errBefore = errPulses;
        applyStimulus(8'h12, 0);
        applyStimulus(8'h34, 1);
        applyStimulus(8'hAF, 0);
        applyStimulus(8'hBC, 2);
        applyStimulus(8'h55, 0);
        for (int i = 0; i < 7; i++) applyStimulus(FRAME[i], i % 4);
        checkOutput("t3_not_locked_before_last", 32'(locked), 32'd0);
        applyStimulus(FRAME[7], 3);
        checkOutput("t3_locked", 32'(locked), 32'd1);
        checkOutput("t3_frame_cnt", 32'(frame_cnt), 32'd1);
        checkOutput("t3_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("t3_no_err_pulses", 32'(errPulses - errBefore), 32'd0);

        // 0xAF replacing index 4 while locked restarts sync at index 1
        applyStimulus(8'hAF, 0);
        applyStimulus(8'hBC, 0);
        applyStimulus(8'hE2, 0);
        applyStimulus(8'h78, 0);
        applyStimulus(8'hAF, 0);
        checkOutput("t4_err_pulse", 32'(err_pulse), 32'd1);
        checkOutput("t4_locked_drops", 32'(locked), 32'd0);
        for (int i = 1; i < 7; i++) applyStimulus(FRAME[i], 0);
        checkOutput("t4_not_locked_before_8d", 32'(locked), 32'd0);
        applyStimulus(FRAME[7], 0);
        checkOutput("t4_relock_on_8d", 32'(locked), 32'd1);
        checkOutput("t4_frame_cnt", 32'(frame_cnt), 32'd2);
        checkOutput("t4_err_cnt", 32'(err_cnt), 32'd1);

        // Saturation on the 2-bit instance, clear coinciding with frame_done
        pulseReset();
        for (int f = 0; f < 5; f++) sendFrame(0);
        checkOutput("t5_cnt2_saturated", 32'(frame_cnt2), 32'd3);
        checkOutput("t5_cnt16_counts", 32'(frame_cnt), 32'd5);
        checkOutput("t5_locked2", 32'(locked2), 32'd1);
        checkOutput("t5_err_cnt2", 32'(err_cnt2), 32'd0);
        for (int i = 0; i < 7; i++) applyStimulus(FRAME[i], 0);
        cnt_clr2 = 1'b1;
        applyStimulus(FRAME[7], 0);
        cnt_clr2 = 1'b0;
        checkOutput("t5_frame_done2", 32'(frame_done2), 32'd1);
        checkOutput("t5_err_pulse2", 32'(err_pulse2), 32'd0);
        checkOutput("t5_clear_wins", 32'(frame_cnt2), 32'd0);
        checkOutput("t5_cnt16_six", 32'(frame_cnt), 32'd6);
        cnt_clr = 1'b1;
        idleCycle();
        cnt_clr = 1'b0;
        checkOutput("t5_clr_frame_cnt", 32'(frame_cnt), 32'd0);
        checkOutput("t5_clr_keeps_lock", 32'(locked), 32'd1);

        // Asynchronous reset mid-frame while locked
        applyStimulus(8'hAF, 0);
        applyStimulus(8'hBC, 0);
        applyStimulus(8'hE2, 0);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t6_async_locked", 32'(locked), 32'd0);
        checkOutput("t6_async_frame_cnt", 32'(frame_cnt2), 32'd0);
        idleCycle();
        idleCycle();
        reset_n = 1'b1;
        idleCycle();
        for (int i = 3; i < 8; i++) applyStimulus(FRAME[i], 0);
        checkOutput("t6_no_lock_on_remainder", 32'(locked), 32'd0);
        checkOutput("t6_no_frame_on_remainder", 32'(frame_cnt), 32'd0);
        sendFrame(0);
        checkOutput("t6_lock_after_full_frame", 32'(locked), 32'd1);
        checkOutput("t6_frame_cnt", 32'(frame_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/seq_checker.md
# seq_checker

Downstream stream checker for the 8-byte pattern source; consumes its registered byte output and verifies that the received stream repeats the fixed 8-entry sequence 0xAF, 0xBC, 0xE2, 0x78, 0xFF, 0xE2, 0x0B, 0x8D. It hunts for the 0xAF frame start, confirms one full frame, then declares lock and reports per-beat mismatches and completed frames with saturating counters. It sits at the end of the generator path as a built-in self-check for link bring-up.

## Interface
- CNT_W, 16, width of frame_cnt and err_cnt (minimum 2)
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- valid  in  1  data strobe; high for one cycle per new byte (generator enable delayed one cycle)
- data  in  8  received byte, sampled only when valid=1
- cnt_clr  in  1  synchronous clear of frame_cnt and err_cnt
- locked  out  1  high while in LOCKED
- err_pulse  out  1  one-cycle pulse per mismatch detected in LOCKED
- frame_done  out  1  one-cycle pulse when beat index 7 matches (SYNC or LOCKED)
- frame_cnt  out  CNT_W  completed frames while locked or on lock entry, saturating
- err_cnt  out  CNT_W  mismatches counted in LOCKED, saturating

## Operation
- State register: HUNT, SYNC, LOCKED; expected index idx[2:0].
- valid=0: no state, idx or counter change; pulses low.
- HUNT: valid and data==0xAF -> SYNC, idx=1; otherwise stay, idx=0.
- SYNC: valid and data==SEQ[idx] -> idx+1; if idx==7 -> LOCKED, idx=0, frame_done, frame_cnt+1.
- SYNC mismatch: data==0xAF -> stay SYNC, idx=1; else -> HUNT, idx=0. No error counted.
- LOCKED: match -> idx+1 (7 wraps to 0); idx==7 match -> frame_done, frame_cnt+1.
- LOCKED mismatch: err_pulse, err_cnt+1, locked drops; data==0xAF -> SYNC, idx=1; else -> HUNT, idx=0.
- Duplicate 0xE2 (idx 2 and 5) is position-checked only; no special handling.
- Counters saturate at all-ones; increment at saturation is dropped.
- cnt_clr: both counters to 0 that cycle; a simultaneous increment is discarded (clear wins). State and idx unaffected.

## Timing
- All outputs registered; response appears the cycle after the sampled valid beat (latency 1).
- locked rises in the same cycle as the frame_done pulse that completes SYNC; falls in the same cycle as err_pulse.
- Back-to-back valid (every cycle) fully supported; no backpressure, no ready.
- Reset (async assert, sync-safe deassert by system): state HUNT, idx 0, locked 0, err_pulse 0, frame_done 0, frame_cnt 0, err_cnt 0. Reset mid-frame discards partial progress.
- First valid beat after reset is checked normally.

## Structure
- Shared package seq_pkg: SEQ_LEN=8, SEQ constant array (8x8 bits), SOF byte 0xAF, state enum type {HUNT, SYNC, LOCKED}; same package to be imported by the generator.
- One sub-module: sat_counter (parameter W; inputs clk, reset_n, clr, inc; output cnt), instantiated twice for frame_cnt and err_cnt.

## Test plan
- Reset, then 8 back-to-back valid beats AF BC E2 78 FF E2 0B 8D -> after 8th beat: frame_done 1 cycle, locked=1, frame_cnt=1, err_cnt=0.
- Locked, send AF BC E2 00 -> err_pulse 1 cycle after 0x00, err_cnt=1, locked=0, state HUNT; following full frame relocks, frame_cnt=2.
- Junk 12 34 AF BC 55 then full frame with valid gaps of 0-3 idle cycles -> no err_pulse, lock after full frame, frame_cnt=1.
- Locked, replace idx 4 byte by AF then send BC E2 78 FF E2 0B 8D -> err_pulse, err_cnt=1, relock on 8D, frame_cnt increments.
- CNT_W=2, 5 clean frames -> frame_cnt=3 (saturated); cnt_clr coincident with frame_done -> frame_cnt=0.
- Assert reset_n low mid-frame while locked -> all outputs zero immediately (asynchronously); after release, remainder of old frame produces no lock until next AF-led full frame.
